// File: rtl/rx_frame_ctrl_if.sv
// Bus bundle between the MAC-side controller and the rx frame window block.
interface rx_frame_ctrl_if #(
  parameter int LEN_WIDTH  = 9,
  parameter int TIME_WIDTH = 16
);
  logic                  start;
  logic                  abort;
  logic [LEN_WIDTH-1:0]  exp_len;
  logic [TIME_WIDTH-1:0] holdoff;
  logic [TIME_WIDTH-1:0] timeout;
  logic                  in_dat;
  logic                  in_vld;
  logic                  rx_rst;
  logic                  out_dat;
  logic                  out_vld;
  logic                  busy;
  logic                  done;
  logic [1:0]            status;
  logic [LEN_WIDTH-1:0]  bit_cnt;

  modport slave (
    input  start, abort, exp_len, holdoff, timeout, in_dat, in_vld,
    output rx_rst, out_dat, out_vld, busy, done, status, bit_cnt
  );

  modport master (
    output start, abort, exp_len, holdoff, timeout, in_dat, in_vld,
    input  rx_rst, out_dat, out_vld, busy, done, status, bit_cnt
  );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Receive-window controller: holdoff, first-bit search, bit counting, gap/timeout, abort.
// Optional CRC-16 residue check of the received frame when RX_CRC16_CHECK_EN is defined.
module rx_frame_ctrl #(
  parameter int LEN_WIDTH  = 9,
  parameter int TIME_WIDTH = 16,
  parameter int GAP_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  rx_frame_ctrl_if.slave bus
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int CW = (TIME_WIDTH > GW) ? TIME_WIDTH : GW;

  typedef enum logic [2:0] {S_IDLE, S_HOLDOFF, S_SEARCH, S_RECEIVE, S_FINISH} state_t;

  state_t                r_state, w_next;
  logic [LEN_WIDTH-1:0]  r_len, r_cnt, w_cnt_inc;
  logic [TIME_WIDTH-1:0] r_hold, r_to;
  logic [CW-1:0]         r_tmr, w_tmr_inc;
  logic [1:0]            r_status, w_status;
  logic                  w_status_we;
  logic                  w_live, w_acc, w_last, w_hold_end, w_to_exp, w_gap_exp, w_crc_bad;
  logic                  r_out_dat, r_out_vld, r_done;

  assign w_live     = (r_state == S_SEARCH) || (r_state == S_RECEIVE);
  // abort wins over a same-cycle bit, so that bit is never forwarded or counted
  assign w_acc      = w_live && bus.in_vld && !bus.abort;
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_last     = w_acc && (w_cnt_inc == r_len);
  // r_tmr counts whole cycles spent in the current state (or since the last bit)
  assign w_tmr_inc  = r_tmr + CW'(1);
  assign w_hold_end = (w_tmr_inc == CW'(r_hold));
  assign w_to_exp   = (r_to != '0) && (w_tmr_inc == CW'(r_to));
  assign w_gap_exp  = (w_tmr_inc == CW'(GAP_CYCLES));

`ifdef RX_CRC16_CHECK_EN
  logic [15:0] r_crc, w_crc_nxt;

  assign w_crc_nxt = {r_crc[14:0], 1'b0} ^ ((r_crc[15] ^ bus.in_dat) ? 16'h1021 : 16'h0000);
  assign w_crc_bad = (w_crc_nxt != 16'h1D0F);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_crc <= '0;
    else if (r_state == S_IDLE && bus.start) r_crc <= 16'hFFFF;
    else if (w_acc)                       r_crc <= w_crc_nxt;
  end
`else
  assign w_crc_bad = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_status_we = 1'b0;
    w_status    = r_status;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.exp_len == '0)      w_next = S_FINISH;
          else if (bus.holdoff == '0) w_next = S_SEARCH;
          else                        w_next = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (bus.abort) begin
          w_next = S_FINISH; w_status_we = 1'b1; w_status = 2'b11;
        end else if (w_hold_end) begin
          w_next = S_SEARCH;
        end
      end
      S_SEARCH, S_RECEIVE: begin
        if (bus.abort) begin
          w_next = S_FINISH; w_status_we = 1'b1; w_status = 2'b11;
        end else if (w_last) begin
          w_next = S_FINISH; w_status_we = 1'b1; w_status = w_crc_bad ? 2'b10 : 2'b00;
        end else if (w_acc) begin
          w_next = S_RECEIVE;
        end else if ((r_state == S_SEARCH) ? w_to_exp : w_gap_exp) begin
          w_next = S_FINISH; w_status_we = 1'b1; w_status = 2'b01;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_hold    <= '0;
      r_to      <= '0;
      r_tmr     <= '0;
      r_cnt     <= '0;
      r_status  <= 2'b00;
      r_out_dat <= 1'b0;
      r_out_vld <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_out_vld <= w_acc;
      r_out_dat <= w_acc & bus.in_dat;
      r_done    <= (r_state == S_FINISH);
      if (w_next != r_state || w_acc) r_tmr <= '0;
      else if (~&r_tmr)               r_tmr <= w_tmr_inc;
      if (r_state == S_IDLE && bus.start) begin
        r_len    <= bus.exp_len;
        r_hold   <= bus.holdoff;
        r_to     <= bus.timeout;
        r_cnt    <= '0;
        r_status <= 2'b00;
      end else begin
        if (w_acc)       r_cnt    <= w_cnt_inc;
        if (w_status_we) r_status <= w_status;
      end
    end
  end

  assign bus.rx_rst  = !w_live;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.out_dat = r_out_dat;
  assign bus.out_vld = r_out_vld;
  assign bus.status  = r_status;
  assign bus.bit_cnt = r_cnt;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Randomized frame-level bench for rx_frame_ctrl with a cycle-plan reference model.
module tb_rx_frame_ctrl;
  localparam int LW = 9, TW = 16, G = 64, MAXC = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_frame_ctrl_if #(.LEN_WIDTH(LW), .TIME_WIDTH(TW)) bus();
  rx_frame_ctrl #(.LEN_WIDTH(LW), .TIME_WIDTH(TW), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_vec = 0, n_err = 0;

  // frame plan, cycles relative to the start pulse (cycle 0)
  int p_h, p_t, p_l, p_ab;
  int bq[$];
  bit bd[$];
  // model results
  int s, f, e_st, e_cnt;
  bit acc [MAXC];
  bit adat[MAXC];
  bit vin [MAXC];
  bit din [MAXC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic plan_clear(input int h, input int t, input int l);
    p_h = h; p_t = t; p_l = l; p_ab = -1;
    bq.delete(); bd.delete();
  endtask

  task automatic add_bit(input int c, input bit d);
    bq.push_back(c); bd.push_back(d);
  endtask

  // Walk the bit plan by the window rules: timeout before first bit, gap between bits,
  // completion at exp_len bits, then abort truncation.
  task automatic model();
    int acq[$];
    logic [15:0] c;
    s = 1 + p_h; f = -1; e_st = 0;
    if (p_l == 0) f = 1;
    else begin
      for (int i = 0; i < bq.size(); i++) begin
        if (i == 0 && p_t != 0 && bq[0] - s >= p_t) begin f = s + p_t; e_st = 1; break; end
        if (i > 0 && bq[i] - bq[i-1] - 1 >= G) begin f = bq[i-1] + G + 1; e_st = 1; break; end
        acq.push_back(i);
        if (acq.size() == p_l) begin f = bq[i] + 1; break; end
      end
      if (f < 0) begin
        e_st = 1;
        f = (acq.size() == 0) ? s + p_t : bq[acq[$]] + G + 1;
      end
    end
    if (p_ab >= 1 && p_ab < f) begin
      f = p_ab + 1; e_st = 3;
      while (acq.size() > 0 && bq[acq[$]] >= p_ab) void'(acq.pop_back());
    end
`ifdef RX_CRC16_CHECK_EN
    if (e_st == 0 && p_l != 0) begin
      c = 16'hFFFF;
      foreach (acq[j]) c = {c[14:0], 1'b0} ^ ((c[15] ^ bd[acq[j]]) ? 16'h1021 : 16'h0000);
      if (c != 16'h1D0F) e_st = 2;
    end
`else
    c = '0;
`endif
    for (int k = 0; k < MAXC; k++) begin acc[k] = 1'b0; adat[k] = 1'b0; end
    foreach (acq[j]) begin acc[bq[acq[j]]] = 1'b1; adat[bq[acq[j]]] = bd[acq[j]]; end
    e_cnt = acq.size();
  endtask

  task automatic run(input bit noise);
    int sp;
    model();
    for (int k = 0; k < MAXC; k++) begin vin[k] = 1'b0; din[k] = 1'b0; end
    if (noise) for (int k = 1; k < s; k++) begin vin[k] = $urandom_range(0, 1); din[k] = $urandom_range(0, 1); end
    foreach (bq[i]) if (bq[i] < MAXC) begin vin[bq[i]] = 1'b1; din[bq[i]] = bd[i]; end
    sp = $urandom_range(1, f);
    for (int k = 0; k <= f + 3; k++) begin
      @(posedge clk); #1;
      if (k >= 1) begin
        chk("out_vld", bus.out_vld, acc[k-1]);
        chk("out_dat", bus.out_dat, acc[k-1] & adat[k-1]);
      end
      chk("done", bus.done, k == f + 1);
      chk("busy", bus.busy, k >= 1 && k <= f);
      chk("rx_rst", bus.rx_rst, !(p_l != 0 && k >= s && k <= f - 1));
      if (k == f + 1 || k == f + 3) begin
        chk("status", bus.status, e_st);
        chk("bit_cnt", bus.bit_cnt, e_cnt);
      end
      bus.start   = (k == 0) || (k == sp);
      bus.exp_len = (k == 0) ? LW'(p_l) : LW'($urandom);
      bus.holdoff = (k == 0) ? TW'(p_h) : TW'($urandom);
      bus.timeout = (k == 0) ? TW'(p_t) : TW'($urandom);
      bus.abort   = (k == p_ab);
      bus.in_vld  = vin[k];
      bus.in_dat  = din[k];
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_vld = 1'b0; bus.in_dat = 1'b0;
  endtask

  task automatic plan_rand();
    int h, t, l, mode, d, c, gi;
    h = $urandom_range(0, 6);
    t = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 40);
    l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
    mode = $urandom_range(0, 4);
    plan_clear(h, t, l);
    if (l != 0) begin
      if (mode == 2 && t != 0) begin
        add_bit(1 + h + t + $urandom_range(0, 3), 1'($urandom));
      end else begin
        d = (t != 0) ? $urandom_range(0, t - 1) : $urandom_range(0, 15);
        if (t != 0 && $urandom_range(0, 2) == 0) d = t - 1;
        c = 1 + h + d;
        add_bit(c, 1'($urandom));
        gi = (mode == 3 && l >= 2) ? $urandom_range(1, l - 1) : -1;
        for (int i = 1; i < l; i++) begin
          if (i == gi) d = G + 1 + $urandom_range(0, 3);
          else d = ($urandom_range(0, 3) == 0) ? G : $urandom_range(1, G);
          c += d;
          add_bit(c, 1'($urandom));
        end
      end
      if (mode == 4) begin
        model();
        if (f >= 2) p_ab = $urandom_range(1, f - 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_vld = 1'b0; bus.in_dat = 1'b0;
    bus.exp_len = '0; bus.holdoff = '0; bus.timeout = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx_rst", bus.rx_rst, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_dat", bus.out_dat, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_bit_cnt", bus.bit_cnt, 0);
    @(negedge clk) rst = 1'b0;

    // holdoff 5, timeout 100, 16 bits every 22 cycles
    plan_clear(5, 100, 16);
    for (int i = 0; i < 16; i++) add_bit(16 + 22 * i, 1'($urandom));
    run(1'b1);
    // no bits, timeout 50
    plan_clear(3, 50, 8);
    run(1'b1);
    // 10 of 32 bits then silence
    plan_clear(2, 0, 32);
    for (int i = 0; i < 10; i++) add_bit(7 + 7 * i, 1'($urandom));
    run(1'b0);
    // abort together with the last bit
    plan_clear(1, 0, 4);
    for (int i = 0; i < 4; i++) add_bit(4 + 3 * i, 1'($urandom));
    p_ab = 13;
    run(1'b0);
    // zero-length window
    plan_clear(0, 0, 0);
    run(1'b0);
    // bit exactly at timeout boundary and at gap boundary both win
    plan_clear(0, 10, 3);
    add_bit(10, 1'b1); add_bit(10 + G, 1'b0); add_bit(10 + 2 * G, 1'b1);
    run(1'b0);

`ifdef RX_CRC16_CHECK_EN
    begin
      logic [15:0] rn, c;
      rn = 16'($urandom);
      c = 16'hFFFF;
      for (int i = 15; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ rn[i]) ? 16'h1021 : 16'h0000);
      c = ~c;
      for (int pass = 0; pass < 2; pass++) begin
        plan_clear(2, 0, 32);
        for (int i = 0; i < 16; i++) add_bit(5 + 2 * i, rn[15-i] ^ (pass == 1 && i == 7));
        for (int i = 0; i < 16; i++) add_bit(37 + 2 * i, c[15-i]);
        run(1'b0);
        chk("crc_status", bus.status, (pass == 0) ? 2'b00 : 2'b10);
      end
    end
`endif

    for (int n = 0; n < 30; n++) begin
      plan_rand();
      run(1'b1);
    end

    // reset in the middle of a window drops the frame without done
    @(posedge clk); #1;
    bus.start = 1'b1; bus.exp_len = LW'(8); bus.holdoff = '0; bus.timeout = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_vld = 1'b1; bus.in_dat = 1'($urandom);
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_rx_rst", bus.rx_rst, 1);
    chk("mrst_bit_cnt", bus.bit_cnt, 0);
    chk("mrst_out_vld", bus.out_vld, 0);
    @(negedge clk);
    rst = 1'b0; bus.in_vld = 1'b0; bus.in_dat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("mrst_done", bus.done, 0);
      chk("mrst_status", bus.status, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 9, width of the expected and received bit counts.
REQ-002 SHALL have parameter TIME_WIDTH, default 16, width of the holdoff and timeout counters.
REQ-003 SHALL have parameter GAP_CYCLES, default 64, maximum clk cycles allowed between accepted bits in RECEIVE.
REQ-004 SHALL have ports: clk in 1, system clock; rst in 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports: start in 1, pulse marking end of TX, begins a receive window.
REQ-006 SHALL have ports: abort in 1, level, terminates the current window.
REQ-007 SHALL have ports: exp_len in LEN_WIDTH, number of bits to receive; holdoff in TIME_WIDTH, turnaround cycles; timeout in TIME_WIDTH, cycles allowed before the first bit arrives.
REQ-008 SHALL have ports: in_dat in 1, in_vld in 1, decoded bit and strobe from the rx path.
REQ-009 SHALL have ports: rx_rst out 1, reset for the rx path (preamble and symbol sync).
REQ-010 SHALL have ports: out_dat out 1, out_vld out 1, forwarded frame bits.
REQ-011 SHALL have ports: busy out 1; done out 1, one-cycle pulse; status out 2; bit_cnt out LEN_WIDTH.

Function
REQ-012 SHALL implement states IDLE, HOLDOFF, SEARCH, RECEIVE, FINISH.
REQ-013 In IDLE, start SHALL latch exp_len, holdoff and timeout, then move to HOLDOFF, or to SEARCH if holdoff==0.
REQ-014 In IDLE, start with exp_len==0 SHALL go to FINISH with status 00 and bit_cnt 0.
REQ-015 start outside IDLE SHALL be ignored.
REQ-016 HOLDOFF SHALL last exactly holdoff cycles and then enter SEARCH; in_vld SHALL be ignored in HOLDOFF.
REQ-017 rx_rst SHALL be 0 only in SEARCH and RECEIVE, and 1 in every other state.
REQ-018 In SEARCH, the first in_vld SHALL enter RECEIVE and count that bit as bit 1.
REQ-019 If no bit arrives within timeout cycles, SEARCH SHALL go to FINISH with status 01; timeout==0 disables this limit.
REQ-020 In RECEIVE, each in_vld SHALL increment bit_cnt; reaching bit_cnt==exp_len SHALL go to FINISH with status 00.
REQ-021 If GAP_CYCLES cycles pass without in_vld in RECEIVE, the block SHALL go to FINISH with status 01.
REQ-022 If in_vld coincides with timeout or gap expiry, the bit SHALL win: it is accepted and no timeout occurs that cycle.
REQ-023 out_dat/out_vld SHALL be registered copies of in_dat/in_vld for accepted bits only, 1-cycle latency; out_vld SHALL be 0 otherwise.
REQ-024 abort in any state other than IDLE SHALL go to FINISH next cycle with status 11, overriding same-cycle completion.
REQ-025 FINISH SHALL last one cycle, assert done, then return to IDLE.
REQ-026 status and bit_cnt SHALL hold their values until the next accepted start.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 done SHALL assert one cycle after the registered out_vld of the last bit.
REQ-029 Counters SHALL saturate and never wrap.

Reset
REQ-030 rst SHALL asynchronously force IDLE, rx_rst=1, out_dat=0, out_vld=0, busy=0, done=0, status=00, bit_cnt=0, and clear the CRC register.
REQ-031 rst asserted mid-window SHALL discard the frame without producing a done pulse.

Configuration
REQ-032 With RX_CRC16_CHECK_EN defined, the block SHALL run a CRC-16 (poly 0x1021, preset 0xFFFF) over accepted bits. On normal completion, if the residue is not 0x1D0F, status SHALL be 10 instead of 00.
REQ-033 Without RX_CRC16_CHECK_EN, no CRC logic SHALL exist and status 10 SHALL never occur.

Verification
REQ-034 start, holdoff=5, timeout=100, exp_len=16, then 16 bits one every 22 cycles -> rx_rst falls 5 cycles after start, 16 out_vld, done with status 00, bit_cnt 16.
REQ-035 start, timeout=50, no in_vld -> done 50 cycles after SEARCH entry, status 01, bit_cnt 0.
REQ-036 exp_len=32, 10 bits then silence -> done GAP_CYCLES after bit 10, status 01, bit_cnt 10.
REQ-037 abort asserted in the same cycle as the last in_vld -> status 11 and exactly one done pulse.
REQ-038 start during RECEIVE, and start with exp_len=0 -> the first is ignored; the second gives done 2 cycles after start, status 00.
REQ-039 With RX_CRC16_CHECK_EN: a valid 16-bit RN16 plus CRC-16 frame -> status 00; the same frame with one bit flipped -> status 10.
